// File: rtl/bcd_timer_display.sv
// mm:ss BCD stopwatch driven by a 1 Hz tick, with a multiplexed common-anode 7-segment scan.
// Optional build macro TIMER_WRAP_EN: wrap 59:59 -> 00:00 and keep running instead of stopping in DONE.
module bcd_timer_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       overflow,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [3:0]    su_n, st_n, mu_n, mt_n;
    logic          term;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;

    // Ripple-carry BCD increment; term flags the 59:59 -> 00:00 rollover.
    always_comb begin
        su_n = sec_bcd[3:0];
        st_n = sec_bcd[7:4];
        mu_n = min_bcd[3:0];
        mt_n = min_bcd[7:4];
        term = 1'b0;
        if (sec_bcd[3:0] == 4'd9) begin
            su_n = 4'd0;
            if (sec_bcd[7:4] == 4'd5) begin
                st_n = 4'd0;
                if (min_bcd[3:0] == 4'd9) begin
                    mu_n = 4'd0;
                    if (min_bcd[7:4] == 4'd5) begin
                        mt_n = 4'd0;
                        term = 1'b1;
                    end else begin
                        mt_n = min_bcd[7:4] + 4'd1;
                    end
                end else begin
                    mu_n = min_bcd[3:0] + 4'd1;
                end
            end else begin
                st_n = sec_bcd[7:4] + 4'd1;
            end
        end else begin
            su_n = sec_bcd[3:0] + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sec_bcd  <= 8'h00;
            min_bcd  <= 8'h00;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            sec_bcd  <= 8'h00;
            min_bcd  <= 8'h00;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
`ifdef TIMER_WRAP_EN
                    if (tick_in) begin
                        sec_bcd <= {st_n, su_n};
                        min_bcd <= {mt_n, mu_n};
                        if (term) overflow <= 1'b1;
                    end
                    if (start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
`else
                    // Reaching the terminal count takes precedence over a coincident pause.
                    if (tick_in && term) begin
                        overflow <= 1'b1;
                        state    <= DONE;
                        running  <= 1'b0;
                    end else begin
                        if (tick_in) begin
                            sec_bcd <= {st_n, su_n};
                            min_bcd <= {mt_n, mu_n};
                        end
                        if (start_stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        an_n      = 4'hF;
        case (digit_idx)
            2'd0: begin cur_digit = sec_bcd[3:0]; an_n = 4'b1110; end
            2'd1: begin cur_digit = sec_bcd[7:4]; an_n = 4'b1101; end
            2'd2: begin cur_digit = min_bcd[3:0]; an_n = 4'b1011; end
            2'd3: begin cur_digit = min_bcd[7:4]; an_n = 4'b0111; end
            default: ;
        endcase
    end

    always_comb begin
        seg_n = 7'h7F;
        case (cur_digit)
            4'd0: seg_n = 7'h40;
            4'd1: seg_n = 7'h79;
            4'd2: seg_n = 7'h24;
            4'd3: seg_n = 7'h30;
            4'd4: seg_n = 7'h19;
            4'd5: seg_n = 7'h12;
            4'd6: seg_n = 7'h02;
            4'd7: seg_n = 7'h78;
            4'd8: seg_n = 7'h00;
            4'd9: seg_n = 7'h10;
            default: seg_n = 7'h7F;
        endcase
    end

    // Scan runs in every state so the display never goes dark outside reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            seg       <= 7'h7F;
            an        <= 4'hF;
        end else begin
            seg <= seg_n;
            an  <= an_n;
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_timer_display.sv
// Self-checking bench for bcd_timer_display: an elapsed-seconds model checked every cycle plus directed literal checks.
// Honours TIMER_WRAP_EN the same way as the design.
`timescale 1ns/1ps
module tb_bcd_timer_display;

    localparam int SCAN_DIV = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] sec_bcd, min_bcd;
    logic       running, overflow;
    logic [6:0] seg;
    logic [3:0] an;

    int total = 0;
    int bad = 0;

    bcd_timer_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .sec_bcd(sec_bcd), .min_bcd(min_bcd), .running(running),
        .overflow(overflow), .seg(seg), .an(an)
    );

    always #5 clk_in = ~clk_in;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Model: elapsed time as a plain number of seconds, display derived from edge count.
    int         m_secs, m_state, m_edges, m_idx;
    int         m_digits [4];
    logic       m_ovf;
    logic [6:0] m_seg;
    logic [3:0] m_an;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_secs = 0; m_state = S_IDLE; m_ovf = 1'b0; m_edges = 0;
            m_seg = 7'h7F; m_an = 4'hF;
        end else begin
            m_idx = (m_edges / SCAN_DIV) % 4;
            m_digits[0] = (m_secs % 60) % 10;
            m_digits[1] = (m_secs % 60) / 10;
            m_digits[2] = (m_secs / 60) % 10;
            m_digits[3] = (m_secs / 60) / 10;
            m_an  = an_seq[m_idx];
            m_seg = seg_tab[m_digits[m_idx]];
            m_edges++;
            if (clear) begin
                m_secs = 0; m_state = S_IDLE; m_ovf = 1'b0;
            end else if (m_state == S_IDLE || m_state == S_PAUSE) begin
                if (start_stop) m_state = S_RUN;
            end else if (m_state == S_RUN) begin
                if (tick_in) begin
                    if (m_secs == 3599) begin
                        m_ovf = 1'b1;
`ifdef TIMER_WRAP_EN
                        m_secs = 0;
`else
                        m_state = S_DONE;
`endif
                    end else begin
                        m_secs++;
                    end
                end
                if (start_stop && m_state == S_RUN) m_state = S_PAUSE;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_in) begin
        checkOutput("model sec_bcd", sec_bcd, to_bcd(m_secs % 60));
        checkOutput("model min_bcd", min_bcd, to_bcd(m_secs / 60));
        checkOutput("model running", 8'(running), 8'(m_state == S_RUN));
        checkOutput("model overflow", 8'(overflow), 8'(m_ovf));
        checkOutput("model seg", 8'(seg), 8'(m_seg));
        checkOutput("model an", 8'(an), 8'(m_an));
    end

    task automatic applyStimulus(input logic ss, input logic tk, input logic clr);
        @(negedge clk_in);
        start_stop = ss; tick_in = tk; clear = clr;
        @(negedge clk_in);
        start_stop = 1'b0; tick_in = 1'b0; clear = 1'b0;
    endtask

    task automatic tickRun(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            tick_in = 1'b1;
        end
        @(negedge clk_in);
        tick_in = 1'b0;
    endtask

    task automatic checkTime(input string name, input logic [7:0] mm, input logic [7:0] ss);
        checkOutput({name, " min"}, min_bcd, mm);
        checkOutput({name, " sec"}, sec_bcd, ss);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk_in);
        checkOutput("reset seg", 8'(seg), 8'h7F);
        checkOutput("reset an", 8'(an), 8'h0F);
        checkTime("reset", 8'h00, 8'h00);
        checkOutput("reset running", 8'(running), 8'h00);
        checkOutput("reset overflow", 8'(overflow), 8'h00);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            @(negedge clk_in);
            checkOutput("scan an", 8'(an), 8'(an_seq[k / 4]));
            checkOutput("scan seg zero", 8'(seg), 8'h40);
        end
        checkTime("idle after scan", 8'h00, 8'h00);

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start running", 8'(running), 8'h01);
        tickRun(10);
        checkTime("ten ticks", 8'h00, 8'h10);
        for (int i = 0; i < 16 && an != 4'b1101; i++) @(negedge clk_in);
        checkOutput("reach digit1", 8'(an), 8'h0D);
        checkOutput("seg tens one", 8'(seg), 8'h79);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickRun(3);
        checkTime("pre pause", 8'h00, 8'h03);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkTime("pause with tick", 8'h00, 8'h04);
        checkOutput("paused running", 8'(running), 8'h00);
        tickRun(3);
        checkTime("ticks while paused", 8'h00, 8'h04);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkTime("resume with tick", 8'h00, 8'h04);
        checkOutput("resumed running", 8'(running), 8'h01);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickRun(60);
        checkTime("minute carry", 8'h01, 8'h00);

        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickRun(3599);
        checkTime("before terminal", 8'h59, 8'h59);
        checkOutput("no overflow yet", 8'(overflow), 8'h00);
        tickRun(1);
`ifdef TIMER_WRAP_EN
        checkTime("wrap", 8'h00, 8'h00);
        checkOutput("wrap overflow", 8'(overflow), 8'h01);
        checkOutput("wrap running", 8'(running), 8'h01);
`else
        checkTime("hold", 8'h59, 8'h59);
        checkOutput("hold overflow", 8'(overflow), 8'h01);
        checkOutput("done running", 8'(running), 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0);
        tickRun(3);
        checkTime("done ignores", 8'h59, 8'h59);
        checkOutput("done stays stopped", 8'(running), 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
`endif
        tickRun(754);
        checkTime("at 12:34", 8'h12, 8'h34);
        checkOutput("12:34 running", 8'(running), 8'h01);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkTime("clear priority", 8'h00, 8'h00);
        checkOutput("clear running", 8'(running), 8'h00);
        checkOutput("clear overflow", 8'(overflow), 8'h00);

        applyStimulus(1'b1, 1'b0, 1'b0);
        tickRun(5);
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        checkTime("async reset", 8'h00, 8'h00);
        checkOutput("async running", 8'(running), 8'h00);
        checkOutput("async overflow", 8'(overflow), 8'h00);
        checkOutput("async seg", 8'(seg), 8'h7F);
        checkOutput("async an", 8'(an), 8'h0F);
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_in);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
